// File: rtl/query_link_arbiter.sv
// Round-robin arbiter sharing one bit-serial query link; frames of NSize+1 slots.
// Define QUERY_PIPELINE_EN to overlap the next address frame with the current reply frame.
module query_link_arbiter #(
    parameter int NSize = 4,
    parameter int NReq  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NReq-1:0]       req,
    input  logic [NReq*NSize-1:0] req_addr,
    output logic [NReq-1:0]       grant,
    output logic [NReq-1:0]       done,
    output logic [NSize-1:0]      rsp_data,
    output logic                  link_reset,
    output logic                  link_out,
    input  logic                  link_in,
    output logic                  busy
);
    localparam int SW = $clog2(NSize + 1);
    localparam int IW = (NReq > 1) ? $clog2(NReq) : 1;

    typedef enum logic [2:0] {ALIGN, IDLE, ADDR, RESP, ADDR_RESP} state_t;

    state_t           state;
    logic [SW-1:0]    slot;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [NSize-1:0] addr_sh;
    logic [NSize-2:0] rsp_sh;
    logic [NSize-1:0] rsp_nxt;
    logic             last;
`ifdef QUERY_PIPELINE_EN
    logic [IW-1:0]    nxt_owner;
    logic             grant_upd;
`endif

    logic [NSize-1:0] addr_v [NReq];
    logic [NReq-1:0]  arb_req;
    logic [IW-1:0]    arb_ptr;
    logic [IW-1:0]    win;
    logic [IW-1:0]    j;
    logic             win_vld;

    function automatic logic [NReq-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] i);
        return (int'(i) == NReq - 1) ? '0 : i + 1'b1;
    endfunction

    for (genvar g = 0; g < NReq; g++) begin : g_addr
        assign addr_v[g] = req_addr[g*NSize +: NSize];
    end

    assign last    = (slot == SW'(NSize));
    assign rsp_nxt = {link_in, rsp_sh};

    // Back-to-back picks exclude requesters already served or in flight, whose
    // req is still legitimately high until their done.
    always_comb begin
        arb_req = req & ~onehot(owner);
        arb_ptr = nxt_idx(owner);
        if (state == IDLE) begin
            arb_req = req;
            arb_ptr = rr_ptr;
        end
`ifdef QUERY_PIPELINE_EN
        if (state == ADDR_RESP) begin
            arb_req = req & ~onehot(owner) & ~onehot(nxt_owner);
            arb_ptr = nxt_idx(nxt_owner);
        end
`endif
        win     = '0;
        win_vld = 1'b0;
        j       = '0;
        for (int i = NReq - 1; i >= 0; i--) begin
            j = IW'((int'(arb_ptr) + i) % NReq);
            if (arb_req[j]) begin
                win     = j;
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ALIGN;
            slot       <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            addr_sh    <= '0;
            rsp_sh     <= '0;
            grant      <= '0;
            done       <= '0;
            rsp_data   <= '0;
            link_out   <= 1'b0;
            link_reset <= 1'b1;
            busy       <= 1'b0;
`ifdef QUERY_PIPELINE_EN
            nxt_owner  <= '0;
            grant_upd  <= 1'b0;
`endif
        end else begin
            done <= '0;
            slot <= (link_reset || last) ? '0 : slot + 1'b1;
`ifdef QUERY_PIPELINE_EN
            // grant follows the new owner one cycle after the previous owner's done
            if (grant_upd) begin
                grant     <= onehot(owner);
                grant_upd <= 1'b0;
            end
`endif
            case (state)
                ALIGN: begin
                    link_reset <= 1'b0;
                    state      <= IDLE;
                end
                IDLE: begin
                    if (last && win_vld) begin
                        grant    <= onehot(win);
                        owner    <= win;
                        busy     <= 1'b1;
                        link_out <= addr_v[win][0];
                        addr_sh  <= addr_v[win] >> 1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (!last) begin
                        link_out <= addr_sh[0];
                        addr_sh  <= addr_sh >> 1;
                    end else begin
`ifdef QUERY_PIPELINE_EN
                        if (win_vld) begin
                            nxt_owner <= win;
                            link_out  <= addr_v[win][0];
                            addr_sh   <= addr_v[win] >> 1;
                            state     <= ADDR_RESP;
                        end else begin
                            link_out <= 1'b0;
                            state    <= RESP;
                        end
`else
                        link_out <= 1'b0;
                        state    <= RESP;
`endif
                    end
                end
                RESP: begin
                    link_out <= 1'b0;
                    if (slot != '0) rsp_sh <= rsp_nxt[NSize-1:1];
                    if (last) begin
                        rsp_data <= rsp_nxt;
                        done     <= onehot(owner);
                        rr_ptr   <= nxt_idx(owner);
`ifdef QUERY_PIPELINE_EN
                        grant    <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
`else
                        // chain straight into the next address frame so transactions
                        // stay exactly two frames apart under contention
                        if (win_vld) begin
                            grant    <= onehot(win);
                            owner    <= win;
                            link_out <= addr_v[win][0];
                            addr_sh  <= addr_v[win] >> 1;
                            state    <= ADDR;
                        end else begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`endif
                    end
                end
`ifdef QUERY_PIPELINE_EN
                ADDR_RESP: begin
                    if (slot != '0) rsp_sh <= rsp_nxt[NSize-1:1];
                    if (!last) begin
                        link_out <= addr_sh[0];
                        addr_sh  <= addr_sh >> 1;
                    end else begin
                        rsp_data  <= rsp_nxt;
                        done      <= onehot(owner);
                        rr_ptr    <= nxt_idx(owner);
                        owner     <= nxt_owner;
                        grant_upd <= 1'b1;
                        if (win_vld) begin
                            nxt_owner <= win;
                            link_out  <= addr_v[win][0];
                            addr_sh   <= addr_v[win] >> 1;
                        end else begin
                            link_out <= 1'b0;
                            state    <= RESP;
                        end
                    end
                end
`endif
                default: state <= ALIGN;
            endcase
        end
    end
endmodule

// File: tb/tb_query_link_arbiter.sv
// Randomised + directed bench: requester agents, serial target peer, scoreboard monitor.
module tb_query_link_arbiter;
    localparam int NSize = 4;
    localparam int NReq  = 4;
`ifdef QUERY_PIPELINE_EN
    localparam int GAP = NSize + 1;
`else
    localparam int GAP = 2 * (NSize + 1);
`endif
    localparam int LAT = 2 * (NSize + 1) + 1;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NReq-1:0]       req = '0;
    logic [NReq*NSize-1:0] req_addr = '0;
    logic [NReq-1:0]       grant, done;
    logic [NSize-1:0]      rsp_data;
    logic                  link_reset, link_out, busy;
    logic                  link_in = 1'b0;

    query_link_arbiter #(.NSize(NSize), .NReq(NReq)) dut (
        .clock(clock), .reset(reset), .req(req), .req_addr(req_addr),
        .grant(grant), .done(done), .rsp_data(rsp_data), .link_reset(link_reset),
        .link_out(link_out), .link_in(link_in), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [NSize-1:0] target_reply(input logic [NSize-1:0] a);
        return a ^ 4'hD;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Serial target: captures the address from each frame, answers it in the next frame.
    int               tslot = 0;
    logic             lr_prev = 1'b1;
    logic [NSize-1:0] cur_addr = '0, reply_cur = '0, rep_sh = '0;
    always @(posedge clock) begin
        #1;
        tslot   = (link_reset || lr_prev) ? 0 : ((tslot == NSize) ? 0 : tslot + 1);
        lr_prev = link_reset;
        if (tslot < NSize) cur_addr = {link_out, cur_addr[NSize-1:1]};
        if (tslot == 0) begin
            rep_sh  = reply_cur;
            link_in = 1'b0;
        end else begin
            link_in = rep_sh[0];
            rep_sh  = rep_sh >> 1;
        end
        if (tslot == NSize) reply_cur = target_reply(cur_addr);
    end

    // Requester agents and scoreboard state
    logic [NSize-1:0] cmd_q   [NReq][$];
    logic [NSize-1:0] exp_rsp [NReq][$];
    int               exp_order [$];
    int               done_cyc [$];
    bit               active    [NReq];
    bit               done_seen [NReq];
    bit               lat_arm   [NReq];
    int               raise_cyc [NReq];
    int               wait_cnt  [NReq];
    int               done_cnt  [NReq];
    logic [NSize-1:0] agent_addr;
    int               mon_idx;

    always @(posedge clock) begin
        #2;
        for (int i = 0; i < NReq; i++) begin
            if (active[i] && done_seen[i]) begin
                active[i] = 1'b0;
                req[i]    = 1'b0;
            end
            done_seen[i] = 1'b0;
            if (!active[i] && reset && cmd_q[i].size() > 0) begin
                agent_addr = cmd_q[i].pop_front();
                req_addr[i*NSize +: NSize] = agent_addr;
                req[i]       = 1'b1;
                active[i]    = 1'b1;
                wait_cnt[i]  = 0;
                raise_cyc[i] = cyc;
                exp_rsp[i].push_back(target_reply(agent_addr));
            end
        end
    end

    always @(negedge clock) begin
        if (reset && done != '0) begin
            chk("done_onehot", $countones(done), 1);
            mon_idx = 0;
            for (int i = 0; i < NReq; i++) if (done[i]) mon_idx = i;
            done_seen[mon_idx] = 1'b1;
            done_cnt[mon_idx]++;
            done_cyc.push_back(cyc);
            if (exp_rsp[mon_idx].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: requester %0d pulsed done with nothing outstanding", mon_idx);
            end else begin
                chk($sformatf("rsp_data_req%0d", mon_idx), int'(rsp_data), int'(exp_rsp[mon_idx].pop_front()));
            end
            if (exp_order.size() > 0) chk("grant_order", mon_idx, exp_order.pop_front());
            if (lat_arm[mon_idx]) begin
                chk("latency", cyc - raise_cyc[mon_idx], LAT);
                lat_arm[mon_idx] = 1'b0;
            end
            chk("rr_wait_bound", int'(wait_cnt[mon_idx] <= NReq), 1);
            for (int i = 0; i < NReq; i++) if (active[i] && i != mon_idx) wait_cnt[i]++;
        end
    end

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 4000 && !ok; k++) begin
            @(negedge clock);
            ok = (busy == 1'b0);
            for (int i = 0; i < NReq; i++) if (active[i] || cmd_q[i].size() != 0) ok = 1'b0;
        end
        chk({name, "_completes"}, int'(ok), 1);
    endtask

    task automatic check_reset_outs(input string name);
        chk({name, "_grant"}, int'(grant), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_rsp_data"}, int'(rsp_data), 0);
        chk({name, "_link_out"}, int'(link_out), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_link_reset"}, int'(link_reset), 1);
    endtask

    task automatic release_reset(input string name);
        @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
        chk({name, "_align_cycle"}, int'(link_reset), 1);
        @(negedge clock);
        chk({name, "_align_done"}, int'(link_reset), 0);
    endtask

    initial begin
        bit got;
        int d0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outs("por");
        release_reset("por");

        // mid-transaction reset aborts without a done
        cmd_q[1].push_back(4'h9);
        repeat (8) @(negedge clock);
        chk("t1_busy_before", int'(busy), 1);
        reset = 1'b0;
        req   = '0;
        exp_order.delete();
        for (int i = 0; i < NReq; i++) begin
            active[i] = 1'b0;
            lat_arm[i] = 1'b0;
            cmd_q[i].delete();
            exp_rsp[i].delete();
        end
        #1 check_reset_outs("t1_mid");
        d0 = done_cnt[1];
        release_reset("t1");

        // round-robin from pointer 0, requester 0 comes back after its done
        for (int i = 0; i < NReq; i++) cmd_q[i].push_back(4'(i + 3));
        cmd_q[0].push_back(4'hE);
        exp_order = '{0, 1, 2, 3, 0};
        wait_idle("t3");
        chk("t1_no_done_after_abort", done_cnt[1] - d0, 1);
        chk("t3_order_consumed", exp_order.size(), 0);

        // single request, latency from an arbitration point
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            got = (tslot == NSize - 1);
        end
        chk("t2_found_slot", int'(got), 1);
        lat_arm[2] = 1'b1;
        cmd_q[2].push_back(4'b1011);
        wait_idle("t2");
        chk("t2_rsp_hold", int'(rsp_data), 4'h6);
        chk("t2_done_low", int'(done), 0);

        // pointer is now 3: requester 3 first, then 0
        exp_order = '{3, 0};
        cmd_q[0].push_back(4'h2);
        cmd_q[3].push_back(4'h7);
        wait_idle("t5");
        chk("t5_order_consumed", exp_order.size(), 0);

        // address change and req drop after grant are ignored
        d0 = done_cnt[1];
        cmd_q[1].push_back(4'h5);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clock);
            got = grant[1];
        end
        chk("t4_granted", int'(got), 1);
        repeat (2) @(negedge clock);
        req_addr[1*NSize +: NSize] = 4'hA;
        req[1] = 1'b0;
        wait_idle("t4");
        repeat (12) @(negedge clock);
        chk("t4_done_once", done_cnt[1] - d0, 1);

        // back-to-back spacing
        done_cyc.delete();
        cmd_q[1].push_back(4'h1);
        cmd_q[2].push_back(4'hC);
        cmd_q[3].push_back(4'h8);
        wait_idle("t6");
        chk("t6_done_count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            chk("t6_gap1", done_cyc[1] - done_cyc[0], GAP);
            chk("t6_gap2", done_cyc[2] - done_cyc[1], GAP);
        end

        // randomised traffic
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 6)) @(negedge clock);
            cmd_q[$urandom_range(0, NReq - 1)].push_back(4'($urandom_range(0, 15)));
        end
        wait_idle("t7");

        for (int i = 0; i < NReq; i++) chk($sformatf("drained_req%0d", i), exp_rsp[i].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
